icache: RTL and testbench
=========================

# icache

Direct-mapped, blocking instruction cache answering the Fetch2 stage's physical fetch requests. Fetch2 presents `p_addr`/`p_addr_valid`; this block returns `cache_ready`/`cache_read`, with zero-cycle hit latency from flop-based storage. Misses refill a full 16-byte line over a simple burst-read port to the memory side.

## Interface
- `NLINE`, default 64: number of lines, power of two; `IDX_W = log2(NLINE)`.
- `LINE_WORDS`, fixed 4: 32-bit words per line; `OFF_W = 4`; `TAG_W = 32 - IDX_W - OFF_W`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `p_addr` in 32: physical fetch address; bits [1:0] are ignored.
- `p_addr_valid` in 1: a fetch request is present.
- `cache_ready` out 1: `cache_read` holds the word at `p_addr` this cycle.
- `cache_read` out 32: instruction word; 0 whenever `cache_ready` = 0.
- `inv` in 1: invalidate all lines (ibar).
- `rd_req` out 1: line-read request; held until accepted.
- `rd_addr` out 32: line-aligned refill address, `{tag, idx, 4'b0}`.
- `rd_rdy` in 1: memory accepts the request in this cycle while `rd_req` = 1.
- `ret_valid` in 1: a refill data beat is present.
- `ret_last` in 1: final beat, asserted with the 4th `ret_valid`.
- `ret_data` in 32: refill beat data. Words arrive in order 0..3.

## Operation
- Address split: tag = `p_addr[31:IDX_W+4]`, idx = `p_addr[IDX_W+3:4]`, word = `p_addr[3:2]`.
- FSM states: IDLE, MISS, REFILL.
- IDLE, hit: `p_addr_valid` is set, `valid[idx]` is set and the tags match. `cache_ready` = 1 combinationally and `cache_read` = `data[idx][word]`.
- IDLE, miss: `p_addr_valid` is set and there is no hit. Latch the tag and idx into `miss_addr`, then go to MISS. `cache_ready` = 0.
- MISS: `rd_req` = 1 and `rd_addr` = `{miss_tag, miss_idx, 4'b0}`. When `rd_rdy` = 1, go to REFILL. `rd_addr` stays stable while `rd_req` is high.
- REFILL: each `ret_valid` beat writes `ret_data` into the line buffer at the beat counter (2 bits), then the counter increments.
- REFILL, `ret_last`: write the tag and data to `miss_idx`, set `valid[miss_idx]` unless the `inv_pend` flag is set, clear the beat counter, and return to IDLE.
- `cache_ready` is 0 in MISS and REFILL. There is no hit-under-miss.
- The requester keeps `p_addr` stable while it is stalled. If `p_addr` changes mid-miss (pipeline clear), the refill still completes for `miss_addr`, then the new address is looked up in IDLE.
- `inv` in IDLE: all `valid` bits clear at the next edge. A lookup in the same cycle still uses the pre-clear valids.
- `inv` in MISS or REFILL: valids clear and `inv_pend` is set. The in-flight line is then written but left invalid. `inv_pend` clears on return to IDLE.
- Reset (async): valids clear, FSM goes to IDLE, `rd_req` = 0, `rd_addr` = 0, beat counter = 0, `inv_pend` = 0.
  - Hence `cache_ready` = 0 and `cache_read` = 0.
  - Data and tag arrays are not reset.
  - Beats arriving after reset while in IDLE are ignored.

## Timing
- Hit: 0 cycles; `cache_ready` is in the same cycle as `p_addr_valid`.
- Miss: entry edge → MISS. `rd_req` is visible the next cycle.
- After a refill, the request hits in the cycle after the `ret_last` edge. Total miss penalty = 2 + (accept wait) + (beat cycles) cycles.
- `ret_valid` may have gaps; the counter only advances on a valid beat.
- A `ret_valid` without `ret_last` on beat 3, or `ret_last` early, is a protocol violation and is not checked.

## Configuration
- `ICACHE_PERF_EN` defined:
  - Adds outputs `perf_hit` [31:0] and `perf_miss` [31:0], both reset to 0 and wrapping at 2^32.
  - `perf_hit` increments on each IDLE hit cycle.
  - `perf_miss` increments on each IDLE→MISS transition.
- Undefined: the ports and counters are absent, with no other behaviour change.

## Structure
- Package `icache_pkg` holds:
  - `LINE_WORDS` and `OFF_W`.
  - The state enum `icache_state_t` (IDLE/MISS/REFILL).
  - Field-extraction helpers for tag, idx and word given `IDX_W`.
- Submodule `icache_line_store` holds the tag, valid and data arrays. It provides combinational read by idx and a synchronous line write, and its valid array is async-cleared by `rstn` and synchronously cleared by `inv`.
- The top level holds the FSM, `miss_addr`, the line buffer, the beat counter and the perf counters.

## Test plan
- Cold miss at 0x1C00_0004: `rd_req`/`rd_addr` = 0x1C00_0000, beats 0xA0..0xA3 → the next cycle gives `cache_ready` = 1 and `cache_read` = 0xA1.
- After that fill, requests to 0x1C00_000C then 0x1C00_0000 → hits in the same cycle returning 0xA3 then 0xA0, with no `rd_req`.
- Conflict: with 0x1C00_0000 resident, request 0x1C00_0400 (same idx, NLINE = 64) → miss, refill, then 0x1C00_0000 misses again.
- `rd_rdy` held low for 5 cycles, then beats with a 2-cycle gap between beats 1 and 2 → `rd_addr` is stable throughout and the data is correct.
- `inv` asserted during REFILL → after `ret_last` the same address misses again; `inv` in IDLE → the next lookup misses.
- `rstn` dropped mid-REFILL → immediately `rd_req` = 0 and `cache_ready` = 0. After release, stray beats are ignored and the first request misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MISS   = 2'd1,
        REFILL = 2'd2
    } icache_state_t;

    // Helpers return right-aligned fields; callers size them to TAG_W / IDX_W.
    function automatic logic [31:0] getTag(input logic [31:0] addr, input int idxW);
        return addr >> (idxW + OFF_W);
    endfunction

    function automatic logic [31:0] getIdx(input logic [31:0] addr, input int idxW);
        return (addr >> OFF_W) & ((32'd1 << idxW) - 32'd1);
    endfunction

    function automatic logic [1:0] getWord(input logic [31:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
interface icache_if;

    logic [31:0] p_addr;
    logic        p_addr_valid;
    logic        cache_ready;
    logic [31:0] cache_read;
    logic        inv;

    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    modport slave (
        input  p_addr, p_addr_valid, inv, rd_rdy, ret_valid, ret_last, ret_data,
        output cache_ready, cache_read, rd_req, rd_addr
    );

    modport master (
        output p_addr, p_addr_valid, inv, rd_rdy, ret_valid, ret_last, ret_data,
        input  cache_ready, cache_read, rd_req, rd_addr
    );

endinterface

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays: combinational read by index, synchronous whole-line write.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NLINE = 64,
    parameter int IDX_W = $clog2(NLINE),
    parameter int TAG_W = 32 - IDX_W - OFF_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [IDX_W-1:0]            rdIdx_i,
    output logic                        rdValid_o,
    output logic [TAG_W-1:0]            rdTag_o,
    output logic [LINE_WORDS-1:0][31:0] rdData_o,
    input  logic                        wrEn_i,
    input  logic [IDX_W-1:0]            wrIdx_i,
    input  logic [TAG_W-1:0]            wrTag_i,
    input  logic [LINE_WORDS-1:0][31:0] wrData_i,
    input  logic                        wrValid_i,
    input  logic                        invAll_i
);

    logic [NLINE-1:0]            valid_q;
    logic [TAG_W-1:0]            tagMem [NLINE];
    logic [LINE_WORDS-1:0][31:0] dataMem [NLINE];

    // Invalidate-all takes priority over a line write landing in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
        end else if (invAll_i) begin
            valid_q <= '0;
        end else if (wrEn_i) begin
            valid_q[wrIdx_i] <= wrValid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            tagMem[wrIdx_i]  <= wrTag_i;
            dataMem[wrIdx_i] <= wrData_i;
        end
    end

    assign rdValid_o = valid_q[rdIdx_i];
    assign rdTag_o   = tagMem[rdIdx_i];
    assign rdData_o  = dataMem[rdIdx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache with zero-cycle hits and 4-beat line refill.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_EN.
module icache
    import icache_pkg::*;
#(
    parameter int NLINE = 64
) (
    input  logic        clk,
    input  logic        rstn,
    icache_if.slave     bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);

    localparam int IDX_W = $clog2(NLINE);
    localparam int TAG_W = 32 - IDX_W - OFF_W;

    icache_state_t               state_q, state_d;
    logic [TAG_W-1:0]            missTag_q, missTag_d;
    logic [IDX_W-1:0]            missIdx_q, missIdx_d;
    logic [1:0]                  beatCnt_q, beatCnt_d;
    logic [LINE_WORDS-1:0][31:0] lineBuf_q, lineBuf_d;
    logic                        invPend_q, invPend_d;

    logic [TAG_W-1:0]            reqTag;
    logic [IDX_W-1:0]            reqIdx;
    logic [1:0]                  reqWord;
    logic                        lookupValid;
    logic [TAG_W-1:0]            lookupTag;
    logic [LINE_WORDS-1:0][31:0] lookupData;
    logic                        hit;
    logic                        fillWrite;
    logic                        fillValid;
    logic [LINE_WORDS-1:0][31:0] fillLine;

    assign reqTag  = TAG_W'(getTag(bus.p_addr, IDX_W));
    assign reqIdx  = IDX_W'(getIdx(bus.p_addr, IDX_W));
    assign reqWord = getWord(bus.p_addr);

    icache_line_store #(
        .NLINE (NLINE),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_store (
        .clk       (clk),
        .rstn      (rstn),
        .rdIdx_i   (reqIdx),
        .rdValid_o (lookupValid),
        .rdTag_o   (lookupTag),
        .rdData_o  (lookupData),
        .wrEn_i    (fillWrite),
        .wrIdx_i   (missIdx_q),
        .wrTag_i   (missTag_q),
        .wrData_i  (fillLine),
        .wrValid_i (fillValid),
        .invAll_i  (bus.inv)
    );

    assign hit             = (state_q == IDLE) && bus.p_addr_valid && lookupValid
                             && (lookupTag == reqTag);
    assign bus.cache_ready = hit;
    assign bus.cache_read  = hit ? lookupData[reqWord] : 32'd0;
    assign bus.rd_req      = (state_q == MISS);
    assign bus.rd_addr     = {missTag_q, missIdx_q, {OFF_W{1'b0}}};

    // An invalidate seen during or alongside the refill leaves the filled line invalid.
    assign fillValid = !(invPend_q || bus.inv);

    always_comb begin
        state_d   = state_q;
        missTag_d = missTag_q;
        missIdx_d = missIdx_q;
        beatCnt_d = beatCnt_q;
        lineBuf_d = lineBuf_q;
        invPend_d = invPend_q;
        fillWrite = 1'b0;
        fillLine  = lineBuf_q;
        fillLine[beatCnt_q] = bus.ret_data;

        unique case (state_q)
            IDLE: begin
                invPend_d = 1'b0;
                if (bus.p_addr_valid && !hit) begin
                    missTag_d = reqTag;
                    missIdx_d = reqIdx;
                    state_d   = MISS;
                end
            end
            MISS: begin
                if (bus.inv) invPend_d = 1'b1;
                if (bus.rd_rdy) state_d = REFILL;
            end
            REFILL: begin
                if (bus.inv) invPend_d = 1'b1;
                if (bus.ret_valid) begin
                    lineBuf_d = fillLine;
                    beatCnt_d = beatCnt_q + 2'd1;
                    if (bus.ret_last) begin
                        fillWrite = 1'b1;
                        beatCnt_d = 2'd0;
                        invPend_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            missTag_q <= '0;
            missIdx_q <= '0;
            beatCnt_q <= '0;
            lineBuf_q <= '0;
            invPend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            missTag_q <= missTag_d;
            missIdx_q <= missIdx_d;
            beatCnt_q <= beatCnt_d;
            lineBuf_q <= lineBuf_d;
            invPend_q <= invPend_d;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perfHit_q, perfMiss_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perfHit_q  <= '0;
            perfMiss_q <= '0;
        end else begin
            if (hit) perfHit_q <= perfHit_q + 32'd1;
            if ((state_q == IDLE) && bus.p_addr_valid && !hit) perfMiss_q <= perfMiss_q + 32'd1;
        end
    end

    assign perf_hit  = perfHit_q;
    assign perf_miss = perfMiss_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized accesses against a line-level model.
module tb_icache;
    import icache_pkg::*;

    localparam int NLINE = 64;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    icache_if bus();

`ifdef ICACHE_PERF_EN
    logic [31:0] perfHit, perfMiss;
    int          expHits   = 0;
    int          expMisses = 0;
`endif

    icache #(.NLINE(NLINE)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit  (perfHit),
        .perf_miss (perfMiss)
`endif
    );

    int          vectors     = 0;
    int          miscompares = 0;
    bit          mValid [NLINE];
    logic [31:0] mLine  [NLINE];

    // Backing memory: the line at 0x1C00_0000 holds 0xA0..0xA3, other lines a hash.
    function automatic logic [31:0] memWord(input logic [31:0] line, input logic [1:0] w);
        if (line == 32'h1C00_0000) return 32'hA0 + {30'd0, w};
        return (line * 32'h9E37_79B9) ^ (32'h0101_0101 * {30'd0, w}) ^ 32'h5A5A_0000;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NLINE; i++) mValid[i] = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One lookup; on a miss plays the memory side of the refill and updates the model.
    task automatic fetch(input logic [31:0] addr, input int rdyWait, input int gap,
                         input bit invInRefill, output bit wasHit);
        logic [31:0] line;
        int          idx;
        line   = addr & 32'hFFFF_FFF0;
        idx    = int'((addr >> 4) % NLINE);
        wasHit = mValid[idx] && (mLine[idx] == line);
        bus.p_addr       = addr;
        bus.p_addr_valid = 1'b1;
        @(negedge clk);
        if (wasHit) begin
            checkOutput("hitReady", {31'd0, bus.cache_ready}, 32'd1);
            checkOutput("hitData", bus.cache_read, memWord(line, addr[3:2]));
            checkOutput("hitNoReq", {31'd0, bus.rd_req}, 32'd0);
`ifdef ICACHE_PERF_EN
            expHits++;
`endif
            nextCycle();
            return;
        end
        checkOutput("missReady", {31'd0, bus.cache_ready}, 32'd0);
        checkOutput("missRead", bus.cache_read, 32'd0);
`ifdef ICACHE_PERF_EN
        expMisses++;
`endif
        nextCycle();
        for (int c = 0; c <= rdyWait; c++) begin
            bus.rd_rdy = (c == rdyWait);
            @(negedge clk);
            checkOutput("rdReq", {31'd0, bus.rd_req}, 32'd1);
            checkOutput("rdAddr", bus.rd_addr, line);
            checkOutput("stallReady", {31'd0, bus.cache_ready}, 32'd0);
            nextCycle();
        end
        bus.rd_rdy = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                for (int g = 0; g < gap; g++) begin
                    bus.ret_valid = 1'b0;
                    @(negedge clk);
                    checkOutput("gapReady", {31'd0, bus.cache_ready}, 32'd0);
                    checkOutput("gapNoReq", {31'd0, bus.rd_req}, 32'd0);
                    nextCycle();
                end
            end
            bus.ret_valid = 1'b1;
            bus.ret_last  = (b == 3);
            bus.ret_data  = memWord(line, 2'(b));
            bus.inv       = invInRefill && (b == 1);
            @(negedge clk);
            checkOutput("refillReady", {31'd0, bus.cache_ready}, 32'd0);
            checkOutput("refillNoReq", {31'd0, bus.rd_req}, 32'd0);
            nextCycle();
        end
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        bus.inv       = 1'b0;
        if (invInRefill) begin
            clearModel();
        end else begin
            mValid[idx] = 1'b1;
            mLine[idx]  = line;
        end
    endtask

    // Keeps requesting one address until it hits, as a stalled Fetch2 stage would.
    task automatic applyStimulus(input logic [31:0] addr, input int rdyWait, input int gap,
                                 input bit invInRefill);
        bit hit;
        for (int t = 0; t < 3; t++) begin
            fetch(addr, rdyWait, gap, invInRefill && (t == 0), hit);
            if (hit) break;
        end
    endtask

    initial begin
        bit          hit;
        logic [31:0] addr;

        rstn             = 1'b0;
        bus.p_addr       = 32'h1C00_0004;
        bus.p_addr_valid = 1'b1;
        bus.inv          = 1'b0;
        bus.rd_rdy       = 1'b0;
        bus.ret_valid    = 1'b0;
        bus.ret_last     = 1'b0;
        bus.ret_data     = 32'd0;
        clearModel();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady", {31'd0, bus.cache_ready}, 32'd0);
        checkOutput("rstRead", bus.cache_read, 32'd0);
        checkOutput("rstRdReq", {31'd0, bus.rd_req}, 32'd0);
        checkOutput("rstRdAddr", bus.rd_addr, 32'd0);
        nextCycle();
        bus.p_addr_valid = 1'b0;
        rstn             = 1'b1;
        nextCycle();

        $display("[TB] cold miss, hits in the filled line, conflict eviction");
        applyStimulus(32'h1C00_0004, 0, 0, 1'b0);
        applyStimulus(32'h1C00_000C, 0, 0, 1'b0);
        applyStimulus(32'h1C00_0000, 0, 0, 1'b0);
        applyStimulus(32'h1C00_0400, 0, 0, 1'b0);
        applyStimulus(32'h1C00_0000, 0, 0, 1'b0);

        $display("[TB] slow accept and gapped beats");
        applyStimulus(32'h2000_0018, 5, 2, 1'b0);
        applyStimulus(32'h2000_0010, 0, 0, 1'b0);

        $display("[TB] invalidate during refill and in idle");
        applyStimulus(32'h2000_0024, 1, 1, 1'b1);
        bus.inv = 1'b1;
        fetch(32'h2000_0028, 0, 0, 1'b0, hit);
        bus.inv = 1'b0;
        clearModel();
        applyStimulus(32'h2000_0028, 0, 0, 1'b0);

        $display("[TB] reset in the middle of a refill");
        bus.p_addr       = 32'h3000_0040;
        bus.p_addr_valid = 1'b1;
        nextCycle();
        bus.rd_rdy = 1'b1;
        nextCycle();
        bus.rd_rdy    = 1'b0;
        bus.ret_valid = 1'b1;
        bus.ret_data  = 32'hDEAD_0000;
        nextCycle();
        rstn = 1'b0;
        #1;
        checkOutput("midRstRdReq", {31'd0, bus.rd_req}, 32'd0);
        checkOutput("midRstReady", {31'd0, bus.cache_ready}, 32'd0);
        checkOutput("midRstRdAddr", bus.rd_addr, 32'd0);
        bus.ret_valid    = 1'b0;
        bus.p_addr_valid = 1'b0;
        clearModel();
`ifdef ICACHE_PERF_EN
        expHits   = 0;
        expMisses = 0;
`endif
        @(negedge clk);
        rstn = 1'b1;
        nextCycle();
        bus.ret_valid = 1'b1;
        bus.ret_data  = 32'hBAD0_0001;
        nextCycle();
        bus.ret_last = 1'b1;
        bus.ret_data = 32'hBAD0_0002;
        @(negedge clk);
        checkOutput("strayRdReq", {31'd0, bus.rd_req}, 32'd0);
        checkOutput("strayReady", {31'd0, bus.cache_ready}, 32'd0);
        nextCycle();
        bus.ret_valid = 1'b0;
        bus.ret_last  = 1'b0;
        applyStimulus(32'h1C00_0008, 0, 0, 1'b0);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            addr = 32'h6000_0000 | ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
                   | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            applyStimulus(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                          ($urandom_range(0, 7) == 0));
        end

`ifdef ICACHE_PERF_EN
        @(negedge clk);
        checkOutput("perfHit", perfHit, 32'(expHits));
        checkOutput("perfMiss", perfMiss, 32'(expMisses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
